// File: rtl/clk_rst_pkg.sv
// Shared types and default parameters for the clock/reset sequencer.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DEBOUNCE  = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    RETRY     = 3'd4
  } state_t;

  localparam int DEF_N_STAGES        = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 1024;
  localparam int DEF_STAGE_GAP       = 16;
  localparam int DEF_LOCK_TIMEOUT    = 1048576;
  localparam int DEF_RETRY_PULSE     = 8;
  localparam int DEF_CNT_W           = 8;

  // Largest of four values; used to size the shared interval timer.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for an asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic r_meta;
  (* ASYNC_REG = "TRUE" *) logic r_sync;

  // Two back-to-back flops; both clear to 0 so lock reads as absent in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Lock-qualified staged reset release with timeout retry and status counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | all stages held in reset, timing out towards a retry
// DEBOUNCE  | lock seen, counting consecutive locked cycles
// RELEASE   | stages dropping one by one, STAGE_GAP apart
// RUN       | all stages released, ready high
// RETRY     | pulsing mmcm_rst_req, lock ignored
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int N_STAGES        = DEF_N_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STAGE_GAP       = DEF_STAGE_GAP,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int RETRY_PULSE     = DEF_RETRY_PULSE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                locked_in,
  output logic [N_STAGES-1:0] rst_stage,
  output logic                ready,
  output logic                mmcm_rst_req,
  output logic [CNT_W-1:0]    lock_loss_cnt,
  output logic [CNT_W-1:0]    retry_cnt
);

  // One timer serves every state; states are exclusive and each transition clears it.
  localparam int TMR_W = $clog2(max4(LOCK_TIMEOUT, DEBOUNCE_CYCLES, STAGE_GAP, RETRY_PULSE));

  localparam logic [TMR_W-1:0] TO_TC  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DEB_TC = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_TC = TMR_W'(STAGE_GAP - 1);
  localparam logic [TMR_W-1:0] PUL_TC = TMR_W'(RETRY_PULSE - 1);

  state_t              r_state, w_state_nx;
  logic [TMR_W-1:0]    r_tmr, w_tmr_nx;
  logic [N_STAGES-1:0] r_rst_stage, w_rst_stage_nx;
  logic                r_ready, w_ready_nx;
  logic                r_req, w_req_nx;
  logic [CNT_W-1:0]    r_loss, w_loss_nx;
  logic [CNT_W-1:0]    r_retry, w_retry_nx;
  logic                w_locked_s;
  logic                w_lock_lost;

  sync_2ff u_sync_lock (
    .clk (clk),
    .rst (rst),
    .i_d (locked_in),
    .o_q (w_locked_s)
  );

  assign w_lock_lost = !w_locked_s &&
                       ((r_state == DEBOUNCE) || (r_state == RELEASE) || (r_state == RUN));

  // Next-state and next-output decode; outputs are registered alongside the state.
  always_comb begin
    w_state_nx     = r_state;
    w_tmr_nx       = r_tmr;
    w_rst_stage_nx = r_rst_stage;
    w_ready_nx     = r_ready;
    w_req_nx       = r_req;
    w_loss_nx      = r_loss;
    w_retry_nx     = r_retry;

    if (w_lock_lost) begin
      w_state_nx     = WAIT_LOCK;
      w_tmr_nx       = '0;
      w_rst_stage_nx = '1;
      w_ready_nx     = 1'b0;
      if (r_loss != '1) w_loss_nx = r_loss + CNT_W'(1);
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          // Lock takes priority over a coincident timeout.
          if (w_locked_s) begin
            w_state_nx = DEBOUNCE;
            w_tmr_nx   = '0;
          end else if (r_tmr == TO_TC) begin
            w_state_nx = RETRY;
            w_tmr_nx   = '0;
            w_req_nx   = 1'b1;
            if (r_retry != '1) w_retry_nx = r_retry + CNT_W'(1);
          end else begin
            w_tmr_nx = r_tmr + TMR_W'(1);
          end
        end
        DEBOUNCE: begin
          if (r_tmr == DEB_TC) begin
            w_state_nx     = RELEASE;
            w_tmr_nx       = '0;
            w_rst_stage_nx = r_rst_stage << 1;
          end else begin
            w_tmr_nx = r_tmr + TMR_W'(1);
          end
        end
        RELEASE: begin
          // Shifting in zeros from bit 0 keeps the release order strictly ascending.
          if (r_tmr == GAP_TC) begin
            w_tmr_nx = '0;
            if (r_rst_stage == '0) begin
              w_state_nx = RUN;
              w_ready_nx = 1'b1;
            end else begin
              w_rst_stage_nx = r_rst_stage << 1;
            end
          end else begin
            w_tmr_nx = r_tmr + TMR_W'(1);
          end
        end
        RUN: begin
          w_tmr_nx = '0;
        end
        RETRY: begin
          if (r_tmr == PUL_TC) begin
            w_state_nx = WAIT_LOCK;
            w_tmr_nx   = '0;
            w_req_nx   = 1'b0;
          end else begin
            w_tmr_nx = r_tmr + TMR_W'(1);
          end
        end
        default: begin
          w_state_nx     = WAIT_LOCK;
          w_tmr_nx       = '0;
          w_rst_stage_nx = '1;
          w_ready_nx     = 1'b0;
          w_req_nx       = 1'b0;
        end
      endcase
    end
  end

  // State, timer, outputs and status counters; rst returns everything to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= WAIT_LOCK;
      r_tmr       <= '0;
      r_rst_stage <= '1;
      r_ready     <= 1'b0;
      r_req       <= 1'b0;
      r_loss      <= '0;
      r_retry     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_tmr       <= w_tmr_nx;
      r_rst_stage <= w_rst_stage_nx;
      r_ready     <= w_ready_nx;
      r_req       <= w_req_nx;
      r_loss      <= w_loss_nx;
      r_retry     <= w_retry_nx;
    end
  end

  assign rst_stage     = r_rst_stage;
  assign ready         = r_ready;
  assign mmcm_rst_req  = r_req;
  assign lock_loss_cnt = r_loss;
  assign retry_cnt     = r_retry;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench for clk_rst_sequencer: expected-output tables pushed to a
// scoreboard at stimulus time, compared when the matching clock edge arrives.
module tb_clk_rst_sequencer;

  localparam int NS  = 3;
  localparam int DEB = 4;
  localparam int GAP = 2;
  localparam int TMO = 20;
  localparam int PUL = 3;
  localparam int CW  = 4;

  typedef struct {
    int         off;
    logic [2:0] stage;
    logic       ready;
    logic       req;
    logic [3:0] loss;
    logic [3:0] retry;
  } vec_t;

  typedef struct {
    int         scen;
    int         off;
    int         cyc;
    logic [2:0] stage;
    logic       ready;
    logic       req;
    logic [3:0] loss;
    logic [3:0] retry;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          locked_in = 1'b0;
  logic [NS-1:0] rst_stage;
  logic          ready;
  logic          mmcm_rst_req;
  logic [CW-1:0] lock_loss_cnt;
  logic [CW-1:0] retry_cnt;

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  vec_t tbl [0:33];
  exp_t sb [$];

  clk_rst_sequencer #(
    .N_STAGES        (NS),
    .DEBOUNCE_CYCLES (DEB),
    .STAGE_GAP       (GAP),
    .LOCK_TIMEOUT    (TMO),
    .RETRY_PULSE     (PUL),
    .CNT_W           (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .locked_in     (locked_in),
    .rst_stage     (rst_stage),
    .ready         (ready),
    .mmcm_rst_req  (mmcm_rst_req),
    .lock_loss_cnt (lock_loss_cnt),
    .retry_cnt     (retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int off, input logic [2:0] st, input logic rd,
                              input logic rq, input int ls, input int rt);
    vec_t v;
    v.off   = off;
    v.stage = st;
    v.ready = rd;
    v.req   = rq;
    v.loss  = 4'(ls);
    v.retry = 4'(rt);
    return v;
  endfunction

  task automatic push_vecs(input int scen, input int base, input int first,
                           input int last, input int loss_add);
    for (int i = first; i <= last; i++) begin
      exp_t e;
      e.scen  = scen;
      e.off   = tbl[i].off;
      e.cyc   = base + tbl[i].off;
      e.stage = tbl[i].stage;
      e.ready = tbl[i].ready;
      e.req   = tbl[i].req;
      e.loss  = 4'(int'(tbl[i].loss) + loss_add);
      e.retry = tbl[i].retry;
      sb.push_back(e);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge and retire due entries.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (ready) begin
      tests++;
      if (rst_stage != '0) begin
        fails++;
        $display("FAIL ready_invariant cyc=%0d: rst_stage=%b with ready=1, want 000", cyc, rst_stage);
      end
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      tests++;
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL s%0d_off%0d: entry for cycle %0d not checked until cycle %0d", e.scen, e.off, e.cyc, cyc);
      end else if ({rst_stage, ready, mmcm_rst_req, lock_loss_cnt, retry_cnt} !==
                   {e.stage, e.ready, e.req, e.loss, e.retry}) begin
        fails++;
        $display("FAIL s%0d_off%0d cyc=%0d: got stage=%b ready=%b req=%b loss=%0d retry=%0d, want stage=%b ready=%b req=%b loss=%0d retry=%0d",
                 e.scen, e.off, cyc, rst_stage, ready, mmcm_rst_req, lock_loss_cnt, retry_cnt,
                 e.stage, e.ready, e.req, e.loss, e.retry);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wait_empty(input int maxc, input int scen);
    int n;
    n = 0;
    while (sb.size() > 0 && n < maxc) begin
      tick();
      n++;
    end
    tests++;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL s%0d_drain: %0d entries left after %0d cycles, want 0", scen, sb.size(), maxc);
      sb.delete();
    end
  endtask

  initial begin
    int c;
    int lk;

    // Clean lock: offsets from edge L
    tbl[0]  = mk(0,  3'b111, 0, 0, 0, 0);
    tbl[1]  = mk(3,  3'b111, 0, 0, 0, 0);
    tbl[2]  = mk(4,  3'b110, 0, 0, 0, 0);
    tbl[3]  = mk(5,  3'b110, 0, 0, 0, 0);
    tbl[4]  = mk(6,  3'b100, 0, 0, 0, 0);
    tbl[5]  = mk(7,  3'b100, 0, 0, 0, 0);
    tbl[6]  = mk(8,  3'b000, 0, 0, 0, 0);
    tbl[7]  = mk(9,  3'b000, 0, 0, 0, 0);
    tbl[8]  = mk(10, 3'b000, 1, 0, 0, 0);
    tbl[9]  = mk(12, 3'b000, 1, 0, 0, 0);
    // Lock loss in RUN: offsets from the cycle locked_in drops
    tbl[10] = mk(1,  3'b000, 1, 0, 0, 0);
    tbl[11] = mk(2,  3'b000, 1, 0, 0, 0);
    tbl[12] = mk(3,  3'b111, 0, 0, 1, 0);
    // Lock loss mid-RELEASE: offsets from edge L
    tbl[13] = mk(0,  3'b111, 0, 0, 0, 0);
    tbl[14] = mk(3,  3'b111, 0, 0, 0, 0);
    tbl[15] = mk(4,  3'b110, 0, 0, 0, 0);
    tbl[16] = mk(5,  3'b111, 0, 0, 1, 0);
    tbl[17] = mk(6,  3'b111, 0, 0, 1, 0);
    tbl[18] = mk(8,  3'b111, 0, 0, 1, 0);
    tbl[19] = mk(10, 3'b111, 0, 0, 1, 0);
    // Two-cycle glitch: offsets from the cycle locked_in rises
    tbl[20] = mk(3,  3'b111, 0, 0, 1, 0);
    tbl[21] = mk(4,  3'b111, 0, 0, 1, 0);
    tbl[22] = mk(5,  3'b111, 0, 0, 2, 0);
    tbl[23] = mk(7,  3'b111, 0, 0, 2, 0);
    // Timeout retries: offsets from the edge WAIT_LOCK is re-entered
    tbl[24] = mk(19,  3'b111, 0, 0, 2, 0);
    tbl[25] = mk(20,  3'b111, 0, 1, 2, 1);
    tbl[26] = mk(21,  3'b111, 0, 1, 2, 1);
    tbl[27] = mk(22,  3'b111, 0, 1, 2, 1);
    tbl[28] = mk(23,  3'b111, 0, 0, 2, 1);
    tbl[29] = mk(43,  3'b111, 0, 1, 2, 2);
    tbl[30] = mk(341, 3'b111, 0, 0, 2, 14);
    tbl[31] = mk(342, 3'b111, 0, 1, 2, 15);
    tbl[32] = mk(365, 3'b111, 0, 1, 2, 15);
    tbl[33] = mk(388, 3'b111, 0, 1, 2, 15);

    // Reset values while rst is held
    tick();
    tick();
    begin
      exp_t e;
      e.scen = 0; e.off = 1; e.cyc = cyc + 1;
      e.stage = 3'b111; e.ready = 1'b0; e.req = 1'b0; e.loss = 4'd0; e.retry = 4'd0;
      sb.push_back(e);
    end
    wait_empty(4, 0);

    // Scenario 1: clean lock, rst released and lock applied together
    c = cyc;
    rst = 1'b0;
    locked_in = 1'b1;
    lk = c + 3;
    push_vecs(1, lk, 0, 9, 0);
    wait_empty(40, 1);

    // Scenario 3: lock loss in RUN, then relock and full sequence again
    c = cyc;
    locked_in = 1'b0;
    push_vecs(3, c, 10, 12, 0);
    wait_cyc(c + 4);
    locked_in = 1'b1;
    push_vecs(3, c + 7, 0, 9, 1);
    wait_empty(40, 3);

    // Scenario 6: async reset between edges while in RUN
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({rst_stage, ready, mmcm_rst_req, lock_loss_cnt, retry_cnt} !==
        {3'b111, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      fails++;
      $display("FAIL s6_async_rst: got stage=%b ready=%b req=%b loss=%0d retry=%0d, want 111 0 0 0 0",
               rst_stage, ready, mmcm_rst_req, lock_loss_cnt, retry_cnt);
    end
    tick();
    c = cyc;
    rst = 1'b0;
    lk = c + 3;

    // Scenario 5: restart after reset, then lock loss right after stage 0 release
    push_vecs(5, lk, 13, 19, 0);
    wait_cyc(lk + 2);
    locked_in = 1'b0;
    wait_empty(40, 5);

    // Scenario 2: two-cycle lock glitch during DEBOUNCE
    c = cyc;
    locked_in = 1'b1;
    push_vecs(2, c, 20, 23, 0);
    wait_cyc(c + 2);
    locked_in = 1'b0;

    // Scenario 4: lock stays low; retries every TMO+PUL cycles, counter saturates
    push_vecs(4, c + 5, 24, 33, 0);
    wait_empty(500, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
Consumes the qualified MMCM/CDCM lock (mmcm_cdcm_locked_level2 from BUFG_CLR_DEV) and generates ordered, staged reset releases for the downstream clock-domain logic.
- Debounces lock before any release.
- Re-asserts all resets immediately on lock loss.
- Requests an MMCM reset pulse if lock is not achieved within a timeout.
- Keeps saturating status counters for slow-control readout.

Parameters:
N_STAGES, 3, number of staged reset outputs; stage 0 is released first.
DEBOUNCE_CYCLES, 1024, consecutive synchronized-locked cycles required before stage 0 releases (min 1).
STAGE_GAP, 16, clk cycles between consecutive stage releases, and between the last release and ready (min 1).
LOCK_TIMEOUT, 1048576, clk cycles spent in WAIT_LOCK before a retry is requested (min 2).
RETRY_PULSE, 8, width in cycles of mmcm_rst_req (min 1).
CNT_W, 8, width of the status counters.

Ports:
clk  in  1  system clock; free-running and independent of the MMCM being monitored.
rst  in  1  asynchronous, active-high reset.
locked_in  in  1  mmcm_cdcm_locked_level2; asynchronous to clk.
rst_stage  out  N_STAGES  active-high staged resets.
ready  out  1  high when all stages are released and lock is stable.
mmcm_rst_req  out  1  MMCM reset request pulse.
lock_loss_cnt  out  CNT_W  saturating count of lock losses after debounce started.
retry_cnt  out  CNT_W  saturating count of timeout retries.

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (rst).
- Reset values:
  - state = WAIT_LOCK; rst_stage = all ones; ready = 0; mmcm_rst_req = 0.
  - lock_loss_cnt = 0; retry_cnt = 0; all internal counters = 0.
- Input synchronization: locked_in passes through a 2-FF synchronizer to give locked_s (2-cycle latency). The FSM uses only locked_s.
- All outputs are registered. Output changes take effect on the same edge as the state transition that causes them.
- WAIT_LOCK:
  - rst_stage all ones, ready 0. timeout counter increments every cycle.
  - locked_s = 1 -> DEBOUNCE, with the debounce counter cleared. Call this edge L.
  - Else, timeout counter reaches LOCK_TIMEOUT-1 -> RETRY.
  - If both conditions hold in the same cycle, lock wins.
- DEBOUNCE:
  - Counter increments while locked_s = 1.
  - locked_s = 0 -> WAIT_LOCK; timeout counter cleared; lock_loss_cnt increments.
  - Counter reaches DEBOUNCE_CYCLES-1 -> RELEASE. rst_stage[0] falls at edge L+DEBOUNCE_CYCLES.
- RELEASE:
  - rst_stage[k] falls at L+DEBOUNCE_CYCLES+k*STAGE_GAP.
  - At L+DEBOUNCE_CYCLES+N_STAGES*STAGE_GAP -> RUN, and ready rises.
  - Stages are released strictly in ascending order and never re-released out of order.
- RUN: holds outputs. locked_s = 0 -> WAIT_LOCK.
- Lock loss in DEBOUNCE, RELEASE or RUN, on the next edge:
  - rst_stage returns to all ones and ready to 0.
  - lock_loss_cnt increments; timeout counter and gap counter are cleared.
- RETRY:
  - mmcm_rst_req = 1 for exactly RETRY_PULSE cycles; retry_cnt increments once on entry.
  - Then -> WAIT_LOCK with the timeout counter cleared.
  - locked_s is ignored during RETRY.
- Counters: lock_loss_cnt and retry_cnt saturate at 2^CNT_W-1 and never wrap. Internal counters are sized with $clog2 of the largest parameter value.
- rst mid-operation: immediate return to the reset values, including clearing the status counters.
- Invariant: ready = 1 implies rst_stage = all zeros.

Decomposition:
- Package clk_rst_pkg: FSM state enum (WAIT_LOCK, DEBOUNCE, RELEASE, RUN, RETRY) and default constants for all parameters.
- Sub-module sync_2ff: single-bit 2-FF synchronizer with ASYNC_REG attribute and asynchronous reset to 0. Instantiated once for locked_in.

Test Plan (all scenarios use N_STAGES=3, DEBOUNCE_CYCLES=4, STAGE_GAP=2, LOCK_TIMEOUT=20, RETRY_PULSE=3, CNT_W=4):
1. Clean lock: locked_in rises and stays high.
   -> DEBOUNCE entered at edge L.
   -> rst_stage goes 111 -> 110 at L+4, 100 at L+6, 000 at L+8.
   -> ready = 1 at L+10; lock_loss_cnt = 0.
2. Glitch: locked_in high for 2 cycles during DEBOUNCE.
   -> rst_stage stays 111 and ready stays 0; lock_loss_cnt = 1; FSM back in WAIT_LOCK.
3. Lock loss in RUN: locked_in drops.
   -> Two cycles later locked_s = 0; on the next edge rst_stage = 111, ready = 0, lock_loss_cnt increments.
   -> After relock, the full sequence from scenario 1 repeats.
4. Timeout: locked_in held low.
   -> mmcm_rst_req high for exactly 3 cycles after 20 WAIT_LOCK cycles; retry_cnt = 1.
   -> Repeats every 23 cycles; retry_cnt saturates at 15 after 15 retries.
5. Lock loss mid-RELEASE (after 110): locked_in drops.
   -> rst_stage = 111; no later stage is released; ready never rises.
6. Async rst asserted in RUN, between clk edges.
   -> All outputs take their reset values immediately.
   -> After rst deassertion, the sequence restarts from WAIT_LOCK.
